axi4_mem_arbiter: RTL and testbench
===================================

Name: axi4_mem_arbiter

Overview:
- Shares the single-port word memory of the AXI4 memory-mapped slave between its write-burst engine and its read-burst engine.
- Ownership is granted per burst: the owner keeps the memory until its last beat, then round-robin arbitration picks the next owner.
- Translates byte addresses to word indices, range-checks them, and returns read data with fixed one-cycle latency.
- Sits between the AXI4 channel FSMs and the memory array.

Parameters:
- DATA_WIDTH, 32, data width of memory words and beats.
- ADDR_WIDTH, 16, byte-address width from the channel engines.
- MEMORY_DEPTH, 1024, number of memory words; word index width MW = $clog2(MEMORY_DEPTH).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- wr_req  in  1  write engine presents a beat
- wr_addr  in  ADDR_WIDTH  byte address of write beat
- wr_data  in  DATA_WIDTH  write beat data
- wr_last  in  1  final beat of write burst
- wr_gnt  out  1  write engine owns memory; beat accepted when wr_req&&wr_gnt
- wr_err  out  1  registered; accepted write beat was out of range
- rd_req  in  1  read engine presents a beat address
- rd_addr  in  ADDR_WIDTH  byte address of read beat
- rd_last  in  1  final beat of read burst
- rd_gnt  out  1  read engine owns memory; beat accepted when rd_req&&rd_gnt
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid, exactly 1 cycle after accepted read beat
- rd_err  out  1  qualifies rd_valid; beat was out of range
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  MW  word index
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  synchronous-read data, valid 1 cycle after mem_en&&!mem_we

Behaviour:
- Clock and reset: ports ACLK and ARESETn; one clock, asynchronous active-low reset.
- Reset values:
  - State: state=IDLE, last_owner=RD.
  - Outputs: wr_gnt=rd_gnt=0, rd_valid=rd_err=wr_err=0, rd_data=0, mem_en=mem_we=0.
  - Reset asserted mid-burst: grants drop immediately (asynchronously); any in-flight rd_valid is cancelled.
- FSM states: IDLE, WR_OWN, RD_OWN. Grants are pure state decodes: wr_gnt=(state==WR_OWN), rd_gnt=(state==RD_OWN).
- IDLE transitions:
  - Only wr_req -> WR_OWN.
  - Only rd_req -> RD_OWN.
  - Both -> the side opposite last_owner. After reset, write wins the first tie.
  - Neither -> stay in IDLE.
- WR_OWN / RD_OWN:
  - Accepted beat with last=1 -> IDLE; last_owner updated to this side.
  - Otherwise stay. req may drop between beats; ownership is held while req is low.
- Arbitration bubble: one IDLE cycle between consecutive bursts, including back-to-back bursts from the same side.
- The non-owner's req is ignored and never causes a memory access.
- Address mapping: word = addr >> 2; in_range = (word < MEMORY_DEPTH); mem_addr = word[MW-1:0].
- Memory drive, combinational from the accepted beat:
  - mem_en = accepted beat && in_range.
  - mem_we = 1 for writes, 0 for reads.
  - mem_wdata = wr_data.
  - No accepted beat: mem_en=0; mem_we, mem_addr, mem_wdata are don't-care, driven 0.
- Out-of-range write: beat is still accepted and still counts toward burst end; no memory write; wr_err=1 for the next cycle.
- Read return:
  - Accepted read beat -> next cycle rd_valid=1.
  - In range: rd_err=0, rd_data=mem_rdata.
  - Out of range: rd_err=1, rd_data=0.
- Read throughput: one beat per cycle sustained, no stalls. rd_valid is not backpressured; the read engine buffers its own data.
- last=1 on the first beat is a single-beat burst. There is no beat limit; bursts end only on last.

Test Plan:
1. Reset, wr_req with 4 beats at addr 0x0010..0x001C, data 0xA0..0xA3, last on beat 4 -> wr_gnt rises 1 cycle after wr_req; memory words 4..7 = 0xA0..0xA3; wr_gnt falls after beat 4.
2. Read burst of 4 at 0x0010 following case 1 -> rd_valid on 4 consecutive cycles, each 1 cycle after its accepted beat, with data 0xA0..0xA3 and rd_err=0.
3. wr_req and rd_req asserted together from reset, both 2-beat bursts, both re-requesting immediately -> grant order WR, RD, WR, RD; one IDLE cycle between bursts.
4. Write to 0x1000 (word 1024, DEPTH=1024) -> mem_en=0, wr_err=1 for 1 cycle; a read of 0x1000 -> rd_valid=1, rd_err=1, rd_data=0.
5. During a read burst, wr_req asserted and rd_req gapped low for 3 cycles mid-burst -> wr_gnt stays 0 until the read last beat, then WR_OWN after 1 IDLE cycle.
6. ARESETn pulsed low during beat 2 of a write burst -> wr_gnt and mem_en drop immediately; after release the state is IDLE and a tie goes to write.

Source files
------------

// File: rtl/axi4_mem_arbiter.sv
// axi4_mem_arbiter: shares the single-port word memory between the AXI4 write-burst engine
// and the read-burst engine.
// Ownership is held for a whole burst. The next owner is chosen round-robin in IDLE.
// Byte addresses are converted to word indices and range-checked. Read data returns
// exactly one cycle after the beat is accepted.
//
// Handshake: a beat is accepted in the cycle where the engine's req and its gnt are both
// high. gnt is a pure decode of the owner state. An engine may drop req between beats and
// still keeps ownership. rd_valid is a one-cycle pulse that is never backpressured.
`timescale 1ns/1ps
module axi4_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024,
    localparam int MW          = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_gnt,
    output logic                  wr_err,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_last,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            o_dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WR_OWN = 2'd1;
    localparam logic [1:0] RD_OWN = 2'd2;

    // last_owner encoding: 0 = write side, 1 = read side
    localparam logic SIDE_WR = 1'b0;
    localparam logic SIDE_RD = 1'b1;

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = MEMORY_DEPTH[ADDR_WIDTH:0];

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_last_owner;
    logic                  w_last_owner_nxt;
    logic                  r_rd_valid;
    logic                  r_rd_err;
    logic                  r_wr_err;

    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic [ADDR_WIDTH-1:0] w_rd_word;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_wr_word     = wr_addr >> 2;
    assign w_rd_word     = rd_addr >> 2;
    assign w_wr_in_range = ({1'b0, w_wr_word} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, w_rd_word} < LP_DEPTH);

    // Grants come straight from the state register, so an asynchronous reset drops them at once.
    assign wr_gnt   = (r_state == WR_OWN);
    assign rd_gnt   = (r_state == RD_OWN);
    assign w_wr_acc = wr_req && wr_gnt;
    assign w_rd_acc = rd_req && rd_gnt;

    assign o_dbg_state = r_state;
    assign rd_valid    = r_rd_valid;
    assign rd_err      = r_rd_err;
    assign wr_err      = r_wr_err;
    // Memory read data is passed through in its return cycle. An error beat returns zero.
    assign rd_data     = (r_rd_valid && !r_rd_err) ? mem_rdata : '0;

    // Memory strobe from the accepted beat. An out-of-range beat touches nothing.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_wr_acc) begin
            mem_en    = w_wr_in_range;
            mem_we    = 1'b1;
            mem_addr  = w_wr_word[MW-1:0];
            mem_wdata = wr_data;
        end else if (w_rd_acc) begin
            mem_en    = w_rd_in_range;
            mem_addr  = w_rd_word[MW-1:0];
        end
    end

    // Ownership FSM: round-robin pick in IDLE, release on the accepted last beat.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            IDLE: begin
                if (wr_req && rd_req)
                    w_state_nxt = (r_last_owner == SIDE_WR) ? RD_OWN : WR_OWN;
                else if (wr_req)
                    w_state_nxt = WR_OWN;
                else if (rd_req)
                    w_state_nxt = RD_OWN;
            end
            WR_OWN: begin
                if (w_wr_acc && wr_last) begin
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = SIDE_WR;
                end
            end
            RD_OWN: begin
                if (w_rd_acc && rd_last) begin
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = SIDE_RD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and last owner. After reset the read side counts as last owner, so write wins the first tie.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= IDLE;
            r_last_owner <= SIDE_RD;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // One-cycle read return and write-error flags. Reset cancels any read that is in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_rd_err   <= w_rd_acc && !w_rd_in_range;
            r_wr_err   <= w_wr_acc && !w_wr_in_range;
        end
    end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Testbench for axi4_mem_arbiter.
// The engines are driven from beat queues, and a word-array memory sits behind the DUT.
// An owner-level model predicts grants, memory strobes and read returns on every cycle.
`timescale 1ns/1ps
module tb_axi4_mem_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        wr_req = 1'b0, wr_last = 1'b0, rd_req = 1'b0, rd_last = 1'b0;
  logic [15:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_gnt, wr_err, rd_gnt, rd_valid, rd_err, mem_en, mem_we;
  logic [31:0] rd_data, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [1:0]  dbg_state;

  axi4_mem_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_gnt(wr_gnt), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
    .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // Synchronous-read single-port memory behind the arbiter
  logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  // ---------------- model and scoreboard state ----------------
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
  logic [31:0] exp_q[$];
  beat_t       wq[$];
  beat_t       rq[$];
  int          gnt_log[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_owner = 0;   // 0 none, 1 write, 2 read
  int          m_last = 2;    // side that owned the memory last
  logic        m_rv = 1'b0, m_rerr = 1'b0, m_werr = 1'b0;
  logic        wr_drop = 1'b0, rd_drop = 1'b0;
  logic        prev_wg = 1'b0, prev_rg = 1'b0;
  int          rd_acc_cnt = 0, rd_gap_at = -1, rd_gap_left = 0;

  function automatic logic inr(logic [15:0] a);
    return ((a >> 2) < 16'd1024);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    m_owner = 0; m_last = 2; m_rv = 1'b0; m_rerr = 1'b0; m_werr = 1'b0;
    exp_q.delete(); wq.delete(); rq.delete();
    prev_wg = 1'b0; prev_rg = 1'b0;
  endfunction

  task automatic push_burst(bit is_wr, logic [15:0] addr, int n, logic [31:0] data0);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr = addr + 16'(4 * i);
      b.data = data0 + 32'(i);
      b.last = (i == n - 1);
      if (is_wr) wq.push_back(b); else rq.push_back(b);
    end
  endtask

  // ---------------- driver + per-cycle check (entered and left at negedge) ----------------
  task automatic step();
    beat_t wb, rb;
    logic wreq, rreq, acc_w, acc_r, exp_en, gap;
    logic [9:0] ea;
    logic [31:0] exp_rd;
    wb = (wq.size() > 0) ? wq[0] : '0;
    rb = (rq.size() > 0) ? rq[0] : '0;
    gap = (rq.size() > 0) && (rd_gap_left > 0) && (rd_acc_cnt == rd_gap_at);
    if (gap) rd_gap_left--;
    wreq = (wq.size() > 0) && !wr_drop;
    rreq = (rq.size() > 0) && !rd_drop && !gap;
    wr_req = wreq; wr_addr = wb.addr; wr_data = wb.data; wr_last = wb.last;
    rd_req = rreq; rd_addr = rb.addr; rd_last = rb.last;
    #1;
    chk("wr_gnt", wr_gnt, m_owner == 1);
    chk("rd_gnt", rd_gnt, m_owner == 2);
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_err", rd_err, m_rerr);
    chk("wr_err", wr_err, m_werr);
    if (m_rv) begin
      exp_rd = exp_q.pop_front();
      chk("rd_data", rd_data, exp_rd);
    end
    acc_w = wreq && (m_owner == 1);
    acc_r = rreq && (m_owner == 2);
    exp_en = (acc_w && inr(wb.addr)) || (acc_r && inr(rb.addr));
    chk("mem_en", mem_en, exp_en);
    if (exp_en) begin
      ea = 10'(acc_w ? (wb.addr >> 2) : (rb.addr >> 2));
      chk("mem_we", mem_we, acc_w);
      chk("mem_addr", mem_addr, ea);
      if (acc_w) chk("mem_wdata", mem_wdata, wb.data);
    end
    if (wr_gnt && !prev_wg) gnt_log.push_back(1);
    if (rd_gnt && !prev_rg) gnt_log.push_back(2);
    prev_wg = wr_gnt; prev_rg = rd_gnt;
    // model: next-cycle outputs and ownership
    m_rv   = acc_r;
    m_rerr = acc_r && !inr(rb.addr);
    m_werr = acc_w && !inr(wb.addr);
    if (acc_r) exp_q.push_back(inr(rb.addr) ? ref_mem[rb.addr >> 2] : 32'h0);
    if (acc_w && inr(wb.addr)) ref_mem[wb.addr >> 2] = wb.data;
    if (m_owner == 0) begin
      if (wreq && rreq) m_owner = (m_last == 1) ? 2 : 1;
      else if (wreq)    m_owner = 1;
      else if (rreq)    m_owner = 2;
    end else if ((acc_w && wb.last) || (acc_r && rb.last)) begin
      m_last = m_owner;
      m_owner = 0;
    end
    if (acc_w) void'(wq.pop_front());
    if (acc_r) begin void'(rq.pop_front()); rd_acc_cnt++; end
    @(negedge ACLK);
  endtask

  task automatic run_drain(int bound, string tag);
    int n;
    n = 0;
    while ((wq.size() > 0 || rq.size() > 0 || m_owner != 0) && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
    step();
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  // Absolute time limit in case the DUT never releases a grant
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int n;
    @(negedge ACLK);
    #1;
    chk("rst_wr_gnt", wr_gnt, 1'b0);
    chk("rst_rd_gnt", rd_gnt, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    apply_reset();

    // 1: four-beat write to words 4..7
    push_burst(1, 16'h0010, 4, 32'hA0);
    run_drain(40, "t1_timeout");
    for (int i = 0; i < 4; i++) chk("t1_mem_word", tb_mem[4 + i], 32'hA0 + 32'(i));

    // 2: read the same four words back
    push_burst(0, 16'h0010, 4, 32'h0);
    run_drain(40, "t2_timeout");

    // 3: tie from reset with both sides re-requesting at once
    apply_reset();
    gnt_log.delete();
    push_burst(1, 16'h0040, 2, 32'hB0);
    push_burst(0, 16'h0010, 2, 32'h0);
    push_burst(1, 16'h0048, 2, 32'hC0);
    push_burst(0, 16'h0040, 2, 32'h0);
    run_drain(60, "t3_timeout");
    chk("t3_gnt_count", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++)
      chk("t3_gnt_order", gnt_log[i], (i % 2 == 0) ? 1 : 2);

    // 4: out-of-range write and read at word 1024
    push_burst(1, 16'h1000, 1, 32'hDEAD);
    run_drain(20, "t4w_timeout");
    push_burst(0, 16'h1000, 1, 32'h0);
    run_drain(20, "t4r_timeout");

    // 5: read burst with a 3-cycle req gap while write waits
    gnt_log.delete();
    rd_acc_cnt = 0; rd_gap_at = 2; rd_gap_left = 3;
    push_burst(0, 16'h0040, 5, 32'h0);
    step(); step();
    push_burst(1, 16'h0080, 2, 32'hE0);
    run_drain(60, "t5_timeout");
    chk("t5_gnt_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t5_first", gnt_log[0], 2);
      chk("t5_second", gnt_log[1], 1);
    end
    rd_gap_at = -1; rd_gap_left = 0;

    // 6: reset pulsed during beat 2 of a write burst
    push_burst(1, 16'h0100, 4, 32'hF0);
    n = 0;
    while (!(m_owner == 1 && wq.size() == 3) && n < 20) begin step(); n++; end
    chk("t6_reach_beat2", 32'(n < 20), 32'd1);
    wr_req = 1'b1; wr_addr = wq[0].addr; wr_data = wq[0].data; wr_last = wq[0].last;
    #1 chk("t6_pre_gnt", wr_gnt, 1'b1);
    #1 ARESETn = 1'b0;
    #1;
    chk("t6_gnt_drop", wr_gnt, 1'b0);
    chk("t6_en_drop", mem_en, 1'b0);
    chk("t6_rv_drop", rd_valid, 1'b0);
    model_reset();
    wr_req = 1'b0;
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    step();
    gnt_log.delete();
    push_burst(1, 16'h0200, 1, 32'h11);
    push_burst(0, 16'h0200, 1, 32'h0);
    run_drain(20, "t6_timeout");
    chk("t6_tie_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("t6_tie_write_first", gnt_log[0], 1);

    // Random traffic: bursts, req gaps and range-boundary addresses
    for (int c = 0; c < 500; c++) begin
      if (wq.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(1, ($urandom_range(0, 3) == 0) ? 16'(16'h0FF0 + $urandom_range(0, 31))
                                                 : 16'($urandom_range(0, 63)),
                   $urandom_range(1, 4), $urandom);
      if (rq.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(0, ($urandom_range(0, 3) == 0) ? 16'(16'h0FF0 + $urandom_range(0, 31))
                                                 : 16'($urandom_range(0, 63)),
                   $urandom_range(1, 4), 32'h0);
      wr_drop = ($urandom_range(0, 3) == 0);
      rd_drop = ($urandom_range(0, 3) == 0);
      step();
    end
    wr_drop = 1'b0; rd_drop = 1'b0;
    run_drain(100, "rand_timeout");
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
